// File: rtl/cache_flush_reader.sv
// Streams a block of RAM words out on a valid/ready interface, optionally
// zeroing each location as it is read. RAM read data is combinational on rdaddress.
module cache_flush_reader #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH-1:0] wraddress,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDR_WIDTH:0] REMAINING_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH:0]     remaining_reg, remaining_next;
  logic                    clr_reg, clr_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    out_last_reg, out_last_next;

  logic capture;
  logic handshake;

  // A new word is taken from RAM whenever the output slot is empty or being drained.
  assign handshake = out_valid_reg && out_ready;
  assign capture   = (state_reg == READ) && (!out_valid_reg || out_ready);

  assign rdaddress = addr_reg;
  assign wraddress = addr_reg;
  assign data      = '0;
  assign wren      = capture && clr_reg && !reset;

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FINISH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      clr_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      clr_reg       <= clr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    clr_next       = clr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;

    // A consumed word empties the slot unless a capture refills it below.
    if (handshake) begin
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next      = base_addr;
          remaining_next = length;
          clr_next       = clear_en;
          state_next     = (length != '0) ? READ : FINISH;
        end
      end
      READ: begin
        if (capture) begin
          out_data_next  = q;
          out_valid_next = 1'b1;
          out_last_next  = (remaining_reg == REMAINING_ONE);
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == REMAINING_ONE) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (handshake) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_flush_reader.sv
// Randomized and directed bench for cache_flush_reader against a queue-based
// model of the expected word stream, RAM contents and done/busy timing.
module tb_cache_flush_reader;
  localparam int DW = 48;
  localparam int AW = 11;
  localparam int N  = 2 ** AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          clear_en = 1'b0;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic [AW-1:0] wraddress;
  logic          wren;
  logic [DW-1:0] data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  cache_flush_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .clear_en(clear_en), .rdaddress(rdaddress), .q(q),
    .wraddress(wraddress), .wren(wren), .data(data), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial forever #5 clock = ~clock;

  // RAM seen by the DUT, and the model's view of what it should contain.
  logic [DW-1:0] ram     [N];
  logic [DW-1:0] exp_ram [N];
  assign q = ram[rdaddress];
  always @(posedge clock) if (wren) ram[wraddress] <= data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0: ready held high, 1: random ready
  int ready_mode = 0;
  always @(posedge clock) begin
    #1 out_ready = (ready_mode == 1) ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  // Model state
  bit            m_busy = 0, m_finish = 0;
  bit            m_clr = 0;
  logic [AW-1:0] m_base = '0;
  int            m_len = 0, m_popped = 0;
  logic [DW-1:0] exp_q[$];
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Observation log for directed literal checks
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  int            obs_cyc[$];
  int            done_cnt = 0, done_cyc = 0, wren_cnt = 0;

  always @(negedge clock) begin
    int            captured;
    bit            exp_wren, fin_next;
    logic [AW-1:0] exp_addr, idx;
    logic [DW-1:0] ew;
    if (reset) begin
      chk(wren == 1'b0, "wren_in_reset", wren, 0);
      m_busy = 0; m_finish = 0; m_popped = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      fin_next = 0;
      chk(busy === m_busy, "busy", busy, m_busy);
      chk(done === m_finish, "done", done, m_finish);
      chk(data == '0, "wr_data_zero", data, 0);
      if (!m_busy || m_finish) chk(out_valid == 1'b0, "valid_outside_flush", out_valid, 0);
      if (prev_stall) begin
        chk(out_valid == 1'b1, "stall_valid", out_valid, 1);
        chk(out_data == prev_data, "stall_data", out_data, prev_data);
        chk(out_last == prev_last, "stall_last", out_last, prev_last);
      end
      captured = m_popped + int'(out_valid);
      exp_wren = m_busy && !m_finish && m_clr && (captured < m_len) && (!out_valid || out_ready);
      chk(wren == exp_wren, "wren", wren, exp_wren);
      exp_addr = m_base + captured[AW-1:0];
      if (m_busy && !m_finish) chk(rdaddress == exp_addr, "rdaddress", rdaddress, exp_addr);
      if (wren) begin
        chk(wraddress == rdaddress, "wraddress", wraddress, rdaddress);
        wren_cnt++;
      end
      if (exp_wren) exp_ram[exp_addr] = '0;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data); obs_last.push_back(out_last); obs_cyc.push_back(cyc);
        chk(m_busy && exp_q.size() != 0, "unexpected_word", out_data, 0);
        if (m_busy && exp_q.size() != 0) begin
          ew = exp_q.pop_front();
          chk(out_data == ew, "word_data", out_data, ew);
          chk(out_last == (exp_q.size() == 0), "word_last", out_last, exp_q.size() == 0);
          m_popped++;
          if (exp_q.size() == 0) fin_next = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (m_finish) begin
        m_busy = 0; m_finish = 0;
      end else if (fin_next) begin
        m_finish = 1;
      end else if (!m_busy && start) begin
        m_busy = 1; m_base = base_addr; m_len = int'(length); m_clr = clear_en; m_popped = 0;
        exp_q.delete();
        for (int i = 0; i < m_len; i++) begin
          idx = base_addr + i[AW-1:0];
          exp_q.push_back(exp_ram[idx]);
        end
        if (m_len == 0) m_finish = 1;
      end
    end
  end

  task automatic clear_log();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    wren_cnt = 0;
  endtask

  task automatic run_flush(input logic [AW-1:0] b, input logic [AW:0] len, input bit clr,
                           input bit spurious, output int c0);
    int d0, t;
    @(posedge clock); #1;
    d0 = done_cnt; base_addr = b; length = len; clear_en = clr; start = 1'b1; c0 = cyc;
    @(posedge clock); #1 start = 1'b0;
    if (spurious && len >= 8) begin
      repeat (2) @(posedge clock);
      #1 start = 1'b1; base_addr = AW'($urandom); length = 3; clear_en = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(posedge clock); t++; end
    chk(done_cnt == d0 + 1, "flush_done_count", done_cnt - d0, 1);
    @(posedge clock);
  endtask

  task automatic check_words(input string name, input logic [DW-1:0] w0, input int n, input int c0);
    chk(obs_data.size() == n, {name, "_count"}, obs_data.size(), n);
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      chk(obs_data[i] == ((w0 + DW'(i)) & DW'(N - 1)), {name, "_word"}, obs_data[i], (w0 + DW'(i)) & DW'(N - 1));
      chk(obs_cyc[i] == c0 + 2 + i, {name, "_cycle"}, obs_cyc[i], c0 + 2 + i);
      chk(obs_last[i] == (i == n - 1), {name, "_last"}, obs_last[i], i == n - 1);
    end
    chk(done_cyc == c0 + 2 + n, {name, "_done_cycle"}, done_cyc, c0 + 2 + n);
  endtask

  initial begin
    int c0, t, d0, mism;
    logic [AW-1:0] rb;
    logic [AW:0]   rl;
    for (int i = 0; i < N; i++) begin
      ram[i] = DW'(i); exp_ram[i] = DW'(i);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk(out_valid == 1'b0, "rst_valid", out_valid, 0);
    chk(out_last == 1'b0, "rst_last", out_last, 0);
    chk(out_data == '0, "rst_data", out_data, 0);
    chk(rdaddress == '0, "rst_addr", rdaddress, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);

    // Plain read, no clear
    clear_log(); run_flush(11'h010, 4, 0, 0, c0);
    check_words("basic", 48'h10, 4, c0);
    chk(wren_cnt == 0, "basic_wren_cnt", wren_cnt, 0);
    for (int i = 0; i < 4; i++) chk(ram[16 + i] == DW'(16 + i), "basic_ram_kept", ram[16 + i], 16 + i);

    // Same read with clear
    clear_log(); run_flush(11'h010, 4, 1, 0, c0);
    check_words("clear", 48'h10, 4, c0);
    chk(wren_cnt == 4, "clear_wren_cnt", wren_cnt, 4);
    for (int i = 0; i < 4; i++) chk(ram[16 + i] == '0, "clear_ram_zero", ram[16 + i], 0);

    // Address wrap
    clear_log(); run_flush(11'h7FE, 4, 0, 0, c0);
    check_words("wrap", 48'h7FE, 4, c0);

    // Random back-pressure
    ready_mode = 1;
    clear_log(); run_flush(11'h100, 8, 0, 0, c0);
    ready_mode = 0;
    chk(obs_data.size() == 8, "stall_count", obs_data.size(), 8);
    for (int i = 0; i < 8 && i < obs_data.size(); i++)
      chk(obs_data[i] == DW'(256 + i), "stall_word", obs_data[i], 256 + i);

    // Zero length
    clear_log(); run_flush(11'h055, 0, 1, 0, c0);
    chk(obs_data.size() == 0, "len0_words", obs_data.size(), 0);
    chk(done_cyc == c0 + 1, "len0_done_cycle", done_cyc, c0 + 1);
    chk(wren_cnt == 0, "len0_wren_cnt", wren_cnt, 0);

    // Reset mid-flush
    clear_log();
    @(posedge clock); #1;
    d0 = done_cnt; base_addr = 11'h200; length = 16; clear_en = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    t = 0;
    while (obs_data.size() < 3 && t < 100) begin @(negedge clock); t++; end
    chk(obs_data.size() == 3, "rst_mid_words", obs_data.size(), 3);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    chk(out_valid == 1'b0, "rst_mid_valid", out_valid, 0);
    chk(out_last == 1'b0, "rst_mid_last", out_last, 0);
    chk(busy == 1'b0, "rst_mid_busy", busy, 0);
    chk(done == 1'b0, "rst_mid_done", done, 0);
    repeat (5) @(posedge clock);
    chk(done_cnt == d0, "rst_mid_no_done", done_cnt - d0, 0);
    clear_log(); run_flush(11'h020, 4, 0, 0, c0);
    check_words("after_rst", 48'h20, 4, c0);

    // Randomized flushes
    for (int k = 0; k < 25; k++) begin
      rb = AW'($urandom);
      rl = (AW + 1)'($urandom_range(0, 40));
      ready_mode = int'($urandom_range(0, 1));
      clear_log();
      run_flush(rb, rl, 1'($urandom), 1'b1, c0);
      chk(obs_data.size() == int'(rl), "rand_count", obs_data.size(), rl);
    end
    ready_mode = 0;

    // Whole RAM in one flush
    clear_log(); run_flush(AW'($urandom), (AW + 1)'(N), 0, 0, c0);
    chk(obs_data.size() == N, "full_count", obs_data.size(), N);
    chk(done_cyc == c0 + 2 + N, "full_done_cycle", done_cyc, c0 + 2 + N);

    mism = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== exp_ram[i]) mism++;
    chk(mism == 0, "ram_contents", mism, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cache_flush_reader.md
CACHE_FLUSH_READER -- requirements
Module: cache_flush_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 48: RAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 11: RAM address width in bits; the RAM holds 2**ADDR_WIDTH words.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a flush; sampled in IDLE only.
REQ-006 base_addr  input  ADDR_WIDTH  first RAM address to read.
REQ-007 length  input  ADDR_WIDTH+1  number of words to read, 0..2**ADDR_WIDTH.
REQ-008 clear_en  input  1  when 1, each word read is overwritten with zero.
REQ-009 rdaddress  output  ADDR_WIDTH  RAM read address.
REQ-010 q  input  DATA_WIDTH  RAM read data; combinational function of rdaddress, no read latency.
REQ-011 wraddress  output  ADDR_WIDTH  RAM write address.
REQ-012 wren  output  1  RAM write enable.
REQ-013 data  output  DATA_WIDTH  RAM write data; constant zero.
REQ-014 out_data  output  DATA_WIDTH  stream word.
REQ-015 out_valid  output  1  out_data holds a valid word.
REQ-016 out_last  output  1  qualifies the final word of a flush; meaningful only while out_valid is 1.
REQ-017 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both 1.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when a flush completes.

Function
REQ-020 The block SHALL have the states IDLE, READ, DRAIN and FINISH.
REQ-021 IDLE: on start=1, latch base_addr into addr, length into remaining and clear_en into clr; move to READ if length>0, otherwise to FINISH.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 rdaddress SHALL equal addr at all times.
REQ-024 Capture condition: state READ and (out_valid=0 or out_ready=1).
REQ-025 On capture, at the next edge:
- out_data <= q
- out_valid <= 1
- out_last <= (remaining==1)
- addr <= addr+1 modulo 2**ADDR_WIDTH
- remaining <= remaining-1
REQ-026 When a capture occurs and clr=1, wren SHALL be 1 combinationally in that cycle, with wraddress=addr and data=0; the captured word is the pre-write content.
REQ-027 In every cycle without a capture, wren SHALL be 0.
REQ-028 The capture with remaining==1 SHALL move the state to DRAIN.
REQ-029 Any handshake that is not accompanied by a capture in the same cycle SHALL clear out_valid and out_last at the next edge.
REQ-030 DRAIN: on the handshake of the last word, move to FINISH.
REQ-031 FINISH: assert done=1 for exactly one cycle, then return to IDLE.
REQ-032 Latency: with out_ready held 1, the first out_valid SHALL occur 2 cycles after the start edge, followed by one word per cycle with no bubbles.
REQ-033 With out_ready=0, out_data, out_valid and out_last SHALL hold stable and no capture or RAM write SHALL occur.
REQ-034 Address wrap-around: base_addr+length > 2**ADDR_WIDTH SHALL continue from address 0.
REQ-035 length=2**ADDR_WIDTH SHALL read every location exactly once.

Reset
REQ-036 While reset=1, wren SHALL be forced to 0.
REQ-037 At the reset edge: state<=IDLE; out_valid, out_last, done, busy <= 0; addr, remaining, clr, out_data <= 0.
REQ-038 Reset mid-flush SHALL abandon the flush with no done pulse; the next start after reset SHALL begin a fresh flush.

Verification
REQ-039 Preload RAM[i]=i; start, base=0x010, length=4, clear_en=0, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 2 cycles after start; out_last only with 0x13; done 1 cycle later; RAM unchanged.
REQ-040 Same flush with clear_en=1 -> same stream; RAM[0x10..0x13]=0 afterwards; wren high on exactly 4 cycles.
REQ-041 base=0x7FE, length=4 -> reads 0x7FE, 0x7FF, 0x000, 0x001 in that order.
REQ-042 Toggle out_ready randomly during a length=8 flush -> 8 words in order with no drop or duplicate; out_data stable while stalled; no wren while stalled.
REQ-043 length=0 -> out_valid never asserts; done asserts 1 cycle after start; wren never asserts.
REQ-044 reset asserted after the 3rd word of a length=16 flush -> outputs cleared at the next edge; no done pulse; a new start flushes normally.
